dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU load/store path and a host port used for program/data loading and debug readback.
- Sits between the core's load/store datapath and the data RAM.
- Serialises accesses through a 3-state FSM with round-robin arbitration.
- Returns per-requester acknowledge and read data, and drives a stall to the CPU.

Parameters:
- D_WIDTH, 32, data and requester address width.
- RAM_AW, 17, RAM address width; the low RAM_AW bits of the winning address drive ram_addr.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Asynchronous, active-low.
- cpu_req  input  1  CPU access request. Held high until cpu_ack.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  D_WIDTH  CPU byte address.
- cpu_wdata  input  D_WIDTH  store data.
- cpu_rdata  output  D_WIDTH  load data. Valid while cpu_ack is high.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_stall  output  1  high while cpu_req is high and cpu_ack is low (combinational).
- host_req, host_we, host_addr, host_wdata, host_rdata, host_ack: same widths and semantics for the host port.
- ram_we  output  1  RAM write enable.
- ram_addr  output  RAM_AW  RAM address.
- ram_wd  output  D_WIDTH  RAM write data.
- ram_rd  input  D_WIDTH  RAM read data (combinational read of ram_addr).

Behaviour:
- Reset (rst low, async) forces:
  - state IDLE, last_grant = HOST
  - ram_we 0, ram_addr 0, ram_wd 0
  - cpu_ack and host_ack 0
  - cpu_rdata and host_rdata 0
- Reset mid-access: in-flight access is dropped, ram_we falls immediately, no ack is issued.
- FSM:
  - IDLE: if neither req is high, stay. If exactly one req is high, latch its we/addr/wdata and owner, go to GRANT.
  - IDLE, both req high: the requester that is not last_grant wins, so the CPU wins the first conflict after reset.
  - GRANT: ram_addr/ram_wd come from the latched values; ram_we = latched we. At the clock edge: the RAM commits any write, ram_rd is captured into the owner's rdata register, last_grant = owner. Go to ACK.
  - ACK: owner's ack = 1 for exactly this cycle; ram_we = 0. Go to IDLE.
- Latency:
  - req seen in IDLE at edge N → GRANT in cycle N+1 → ack in cycle N+2.
  - Minimum spacing between accesses: 3 cycles.
- Handshake rules:
  - A requester keeps req, we, addr and wdata stable until its ack.
  - It must drop req by the edge ending the ack cycle; req still high in the following IDLE cycle is a new access.
  - Requester inputs changing during GRANT have no effect, because values are latched.
- Non-owner's rdata register holds its previous value; the non-owner's ack stays 0.
- On a store, the owner's rdata captures ram_rd at the old contents of the address; contents are don't-care for the requester.
- Address: no range check. Upper address bits above RAM_AW are ignored, so out-of-range addresses wrap into the RAM.
- Fairness: with both requesters continuously asserting req, grants strictly alternate, so no requester waits more than one foreign access (≤5 cycles from req to GRANT).

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined: adds outputs cpu_grant_cnt[15:0], host_grant_cnt[15:0] and conflict_cnt[15:0].
  - Grant counters increment on each IDLE→GRANT for their owner.
  - conflict_cnt increments when both req are high in IDLE.
  - All three saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst low for 2 cycles, then high, no requests.
  - Response: all outputs 0, ram_we never asserted.
- Host write then CPU read:
  - Stimulus: host stores 0xDEADBEEF to 0x00000010, then the CPU loads 0x00000010.
  - Response: host_ack 2 cycles after IDLE sample; cpu_rdata = 0xDEADBEEF with cpu_ack; cpu_stall high for exactly 2 cycles.
- Simultaneous requests after reset:
  - Stimulus: cpu_req and host_req rise together, both loads.
  - Response: CPU granted first (cpu_ack at cycle +2), host_ack at cycle +5; with DMEM_ARB_PERF_EN, conflict_cnt = 1.
- Sustained contention:
  - Stimulus: both requesters re-request immediately for 10 accesses each.
  - Response: acks alternate CPU, HOST, CPU, …; each requester gets exactly 10 acks in 60 cycles.
- Reset mid-write:
  - Stimulus: rst asserted during GRANT of a store of 0x12345678 to 0x20.
  - Response: ram_we drops asynchronously, no ack; a later read of 0x20 returns the pre-reset contents.
- Address wrap:
  - Stimulus: CPU stores 0xA5A5A5A5 to address 0x00020004 with RAM_AW = 17.
  - Response: ram_addr = 0x00004 during GRANT; a host read of 0x00000004 returns 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU load/store
// path and the host port. Optional grant/conflict counters: define DMEM_ARB_PERF_EN.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int D_WIDTH = 32,
  parameter int RAM_AW  = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [D_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               cpu_ack,
  output logic               cpu_stall,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [D_WIDTH-1:0] host_addr,
  input  logic [D_WIDTH-1:0] host_wdata,
  output logic [D_WIDTH-1:0] host_rdata,
  output logic               host_ack,
  output logic               ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [D_WIDTH-1:0] ram_wd,
  input  logic [D_WIDTH-1:0] ram_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]        cpu_grant_cnt,
  output logic [15:0]        host_grant_cnt,
  output logic [15:0]        conflict_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic                 ram_we_q, ram_we_d;
  logic [RAM_AW-1:0]    ram_addr_q, ram_addr_d;
  logic [D_WIDTH-1:0]   ram_wd_q, ram_wd_d;
  logic [D_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [D_WIDTH-1:0]   host_rdata_q, host_rdata_d;
  logic                 cpu_ack_q, cpu_ack_d;
  logic                 host_ack_q, host_ack_d;

  logic                 any_req_s;
  logic                 both_req_s;
  logic                 winner_s;
  logic                 win_we_s;
  logic [D_WIDTH-1:0]   win_addr_s;
  logic [D_WIDTH-1:0]   win_wd_s;
  logic                 addr_unused_s;

  // Address bits above the RAM window are deliberately dropped so accesses wrap.
  assign addr_unused_s = ^{cpu_addr[D_WIDTH-1:RAM_AW], host_addr[D_WIDTH-1:RAM_AW]};

  assign any_req_s  = cpu_req | host_req;
  assign both_req_s = cpu_req & host_req;

  // Winner selection: on conflict the side not served last wins.
  always_comb begin
    winner_s = OWN_CPU;
    if (both_req_s) begin
      winner_s = (last_grant_q == OWN_CPU) ? OWN_HOST : OWN_CPU;
    end else if (host_req) begin
      winner_s = OWN_HOST;
    end else begin
      winner_s = OWN_CPU;
    end
  end

  assign win_we_s   = (winner_s == OWN_HOST) ? host_we    : cpu_we;
  assign win_addr_s = (winner_s == OWN_HOST) ? host_addr  : cpu_addr;
  assign win_wd_s   = (winner_s == OWN_HOST) ? host_wdata : cpu_wdata;

  // Next-state and registered-output logic for the IDLE/GRANT/ACK sequence.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wd_d     = ram_wd_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          owner_d    = winner_s;
          ram_we_d   = win_we_s;
          ram_addr_d = win_addr_s[RAM_AW-1:0];
          ram_wd_d   = win_wd_s;
          state_d    = ST_GRANT;
        end else begin
          ram_we_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        ram_we_d     = 1'b0;
        last_grant_d = owner_q;
        state_d      = ST_ACK;
        if (owner_q == OWN_HOST) begin
          host_rdata_d = ram_rd;
          host_ack_d   = 1'b1;
        end else begin
          cpu_rdata_d  = ram_rd;
          cpu_ack_d    = 1'b1;
        end
      end
      ST_ACK: begin
        ram_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        ram_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      last_grant_q <= OWN_HOST;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= {RAM_AW{1'b0}};
      ram_wd_q     <= {D_WIDTH{1'b0}};
      cpu_rdata_q  <= {D_WIDTH{1'b0}};
      host_rdata_q <= {D_WIDTH{1'b0}};
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wd_q     <= ram_wd_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
    end
  end

  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wd     = ram_wd_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign cpu_stall  = cpu_req & ~cpu_ack_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] cpu_cnt_q;
  logic [15:0] host_cnt_q;
  logic [15:0] conf_cnt_q;
  logic        take_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  assign take_s = (state_q == ST_IDLE) & any_req_s;

  // Saturating grant and conflict counters, sampled on IDLE->GRANT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_cnt_q  <= 16'd0;
      host_cnt_q <= 16'd0;
      conf_cnt_q <= 16'd0;
    end else begin
      if (take_s && (winner_s == OWN_CPU)) begin
        cpu_cnt_q <= sat_inc(cpu_cnt_q);
      end else begin
        cpu_cnt_q <= cpu_cnt_q;
      end
      if (take_s && (winner_s == OWN_HOST)) begin
        host_cnt_q <= sat_inc(host_cnt_q);
      end else begin
        host_cnt_q <= host_cnt_q;
      end
      if (take_s && both_req_s) begin
        conf_cnt_q <= sat_inc(conf_cnt_q);
      end else begin
        conf_cnt_q <= conf_cnt_q;
      end
    end
  end

  assign cpu_grant_cnt  = cpu_cnt_q;
  assign host_grant_cnt = host_cnt_q;
  assign conflict_cnt   = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural RAM model; expected read
// data is queued when an access is driven and compared when its ack appears.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_ack;
  logic [DW-1:0] host_addr, host_wdata, host_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wd, ram_rd;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   cpu_grant_cnt, host_grant_cnt, conflict_cnt;
`endif

  dmem_arbiter #(.D_WIDTH(DW), .RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd), .ram_rd(ram_rd)
`ifdef DMEM_ARB_PERF_EN
    , .cpu_grant_cnt(cpu_grant_cnt), .host_grant_cnt(host_grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int a);
    return 32'h5A000000 | 32'(a);
  endfunction

  // RAM model: combinational read, write at the clock edge, preset on first edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mem_init_done = 1'b0;
  assign ram_rd = mem[ram_addr];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wd;
    end
  end

  logic [31:0] model_mem [int];
  function automatic logic [31:0] model_read(input int a);
    return model_mem.exists(a) ? model_mem[a] : pat(a);
  endfunction

  typedef struct { logic we; logic [31:0] data; } exp_t;
  exp_t cpu_q[$];
  exp_t host_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cpu_acks = 0, host_acks = 0, stall_cnt = 0;
  bit alt_mode = 1'b0, idle_mode = 1'b0;
  logic last_acker = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access from either port; returns the cycles from req to ack (-1 on timeout).
  task automatic access(input bit host, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    exp_t e;
    int   a;
    int   t0;
    a = int'(addr[AW-1:0]);
    e.we = we;
    e.data = model_read(a);
    if (we) model_mem[a] = wdata;
    if (host) begin
      host_q.push_back(e);
      host_we = we; host_addr = addr; host_wdata = wdata; host_req = 1'b1;
    end else begin
      cpu_q.push_back(e);
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    t0 = cyc;
    lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (host ? host_ack : cpu_ack) lat = cyc - t0;
    end
    if (host) host_req = 1'b0;
    else cpu_req = 1'b0;
    if (lat < 0) check_eq(host ? "host_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Output monitor: pops the scoreboard on each ack, checks order and idle behaviour.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_stall) stall_cnt++;
      if (idle_mode && ram_we) check_eq("idle_ram_we", 32'(ram_we), 32'd0);
      if (cpu_ack && host_ack) check_eq("ack_exclusive", 32'd1, 32'd0);
      if (cpu_ack) begin
        cpu_acks++;
        if (cpu_q.size() == 0) check_eq("cpu_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = cpu_q.pop_front();
          if (!e.we) check_eq("cpu_rdata", cpu_rdata, e.data);
        end
        if (alt_mode) check_eq("alt_order_cpu", 32'(last_acker), 32'd1);
        last_acker = 1'b0;
      end
      if (host_ack) begin
        host_acks++;
        if (host_q.size() == 0) check_eq("host_unexpected_ack", 32'd1, 32'd0);
        else begin
          e = host_q.pop_front();
          if (!e.we) check_eq("host_rdata", host_rdata, e.data);
        end
        if (alt_mode) check_eq("alt_order_host", 32'(last_acker), 32'd0);
        last_acker = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat_c, lat_h, t0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

    // Reset then idle
    idle_mode = 1'b1;
    do_reset();
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_wd", ram_wd, 32'd0);
    check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check_eq("rst_host_ack", 32'(host_ack), 32'd0);
    check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_eq("rst_host_rdata", host_rdata, 32'd0);
    check_eq("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    repeat (5) @(posedge clk);
    #1 idle_mode = 1'b0;
`ifdef DMEM_ARB_PERF_EN
    check_eq("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif

    // Host write then CPU read
    access(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat_h);
    check_eq("host_store_latency", 32'(lat_h), 32'd2);
    stall_cnt = 0;
    access(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat_c);
    check_eq("cpu_load_latency", 32'(lat_c), 32'd2);
    check_eq("cpu_load_value", cpu_rdata, 32'hDEAD_BEEF);
    check_eq("cpu_stall_cycles", 32'(stall_cnt), 32'd2);

    // Simultaneous requests after reset
    do_reset();
    fork
      access(1'b0, 1'b0, 32'h0000_0040, 32'h0, lat_c);
      access(1'b1, 1'b0, 32'h0000_0044, 32'h0, lat_h);
    join
    check_eq("conflict_cpu_latency", 32'(lat_c), 32'd2);
    check_eq("conflict_host_latency", 32'(lat_h), 32'd5);
    check_eq("cpu_rdata_hold", cpu_rdata, pat(32'h40));
`ifdef DMEM_ARB_PERF_EN
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'd1);
    check_eq("cpu_grant_cnt", 32'(cpu_grant_cnt), 32'd1);
    check_eq("host_grant_cnt", 32'(host_grant_cnt), 32'd1);
`endif

    // Sustained contention
    do_reset();
    alt_mode = 1'b1; last_acker = 1'b1; cpu_acks = 0; host_acks = 0;
    t0 = cyc;
    fork
      begin
        int l;
        for (int i = 0; i < 10; i++)
          access(1'b0, (i % 3) == 0, 32'h100 + 32'(i), 32'hC0000000 + 32'(i), l);
      end
      begin
        int l;
        for (int j = 0; j < 10; j++)
          access(1'b1, (j % 4) == 1, 32'h200 + 32'(j), 32'hB0000000 + 32'(j), l);
      end
    join
    alt_mode = 1'b0;
    check_eq("contention_cpu_acks", 32'(cpu_acks), 32'd10);
    check_eq("contention_host_acks", 32'(host_acks), 32'd10);
    check_eq("contention_cycles", 32'(cyc - t0), 32'd60);

    // Reset mid-write
    access(1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, lat_h);
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h1234_5678; cpu_req = 1'b1;
    @(posedge clk); #1;
    check_eq("grant_ram_we", 32'(ram_we), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("async_ram_we_drop", 32'(ram_we), 32'd0);
    check_eq("async_no_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat_h);
    check_eq("post_reset_read", host_rdata, 32'h1111_1111);

    // Address wrap
    fork
      access(1'b0, 1'b1, 32'h0002_0004, 32'hA5A5_A5A5, lat_c);
      begin
        @(posedge clk); #2;
        check_eq("wrap_ram_we", 32'(ram_we), 32'd1);
        check_eq("wrap_ram_addr", 32'(ram_addr), 32'h0000_0004);
        check_eq("wrap_ram_wd", ram_wd, 32'hA5A5_A5A5);
      end
    join
    access(1'b1, 1'b0, 32'h0000_0004, 32'h0, lat_h);
    check_eq("wrap_readback", host_rdata, 32'hA5A5_A5A5);
    check_eq("scoreboard_drained", 32'(cpu_q.size() + host_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
